// File: rtl/clic_pkg.sv
// Shared types for the CLIC interrupt transmitter: candidate record, FSM
// encoding and the pairwise arbitration rule used by the comparator tree.
package clic_pkg;
  localparam int NUM_SRC = 256;
  localparam int SRC_W   = $clog2(NUM_SRC);
  localparam int LVL_W   = 8;

  typedef struct packed {
    logic             valid;
    logic [SRC_W-1:0] id;
    logic [LVL_W-1:0] level;
    logic [1:0]       priv;
    logic             shv;
  } clic_cand_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    KILL = 2'd2
  } clic_state_e;

  // Higher level wins; equal levels resolve to the higher ID.
  function automatic clic_cand_t clic_pick(input clic_cand_t a, input clic_cand_t b);
    if (!a.valid) return b;
    if (!b.valid) return a;
    if (a.level != b.level) return (a.level > b.level) ? a : b;
    return (a.id > b.id) ? a : b;
  endfunction
endpackage

// File: rtl/clic_max_tree.sv
// Balanced comparator tree selecting the highest-level requesting source.
// Heap layout: node n has children 2n+1 and 2n+2, leaves sit at the bottom.
module clic_max_tree
  import clic_pkg::*;
#(
  parameter int NumSrc = NUM_SRC
) (
  input  logic [NumSrc-1:0]       req_i,
  input  logic [NumSrc*LVL_W-1:0] ctl_i,
  input  logic [NumSrc*2-1:0]     mode_i,
  input  logic [NumSrc-1:0]       shv_i,
  output clic_cand_t              win_o
);
  localparam int Depth  = (NumSrc > 1) ? $clog2(NumSrc) : 1;
  localparam int Leaves = 1 << Depth;

  clic_cand_t node [2*Leaves-1];

  always_comb begin
    node = '{default: '0};
    for (int i = 0; i < Leaves; i++) begin
      if (i < NumSrc) begin
        node[Leaves-1+i].valid = req_i[i];
        node[Leaves-1+i].id    = SRC_W'(i);
        node[Leaves-1+i].level = ctl_i[i*LVL_W +: LVL_W];
        node[Leaves-1+i].priv  = mode_i[i*2 +: 2];
        node[Leaves-1+i].shv   = shv_i[i];
      end
    end
    for (int n = Leaves-2; n >= 0; n--) begin
      node[n] = clic_pick(node[2*n+1], node[2*n+2]);
    end
    win_o = node[0];
  end
endmodule

// File: rtl/clic_irq_target.sv
// CLIC-side transmitter for the core's interrupt port: arbitrates pending
// sources, offers the winner with valid/ready and withdraws stale offers.
module clic_irq_target
  import clic_pkg::*;
#(
  parameter int NumSrc = NUM_SRC,
  parameter int SrcW   = $clog2(NumSrc),
  parameter int LvlW   = LVL_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumSrc-1:0]      ip_i,
  input  logic [NumSrc-1:0]      ie_i,
  input  logic [NumSrc*LvlW-1:0] ctl_i,
  input  logic [NumSrc*2-1:0]    mode_i,
  input  logic [NumSrc-1:0]      shv_i,
  input  logic [LvlW-1:0]        thresh_i,
  output logic                   irq_valid_o,
  input  logic                   irq_ready_i,
  output logic [SrcW-1:0]        irq_id_o,
  output logic [LvlW-1:0]        irq_level_o,
  output logic [1:0]             irq_priv_o,
  output logic                   irq_shv_o,
  output logic                   irq_kill_req_o,
  input  logic                   irq_kill_ack_i,
  output logic                   accept_o,
  output logic [SrcW-1:0]        accept_id_o,
  output clic_state_e            dbg_state_o
);
  // Handshake: an offer transfers in any cycle where irq_valid_o and
  // irq_ready_i are both high; payload is frozen while valid is high, and a
  // withdrawal holds irq_kill_req_o until the cycle irq_kill_ack_i is seen.
  clic_state_e state_q, state_d;
  clic_cand_t  win, cand_q;
  logic [LvlW-1:0] thresh_q;
  logic            valid_q, valid_d, kill_q, kill_d;
  logic [SrcW-1:0] id_q, id_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [1:0]      priv_q, priv_d;
  logic            shv_q, shv_d;
  logic            block_vld_q, block_vld_d;
  logic [SrcW-1:0] block_id_q, block_id_d;
  logic [NumSrc-1:0] mask, req;
  logic accept, eligible, offered_live, outranked, below;

  assign accept = (state_q == SEND) && irq_ready_i;

  // Hide the just-accepted source while its pending bit is still being cleared.
  always_comb begin
    mask = '0;
    if (accept)      mask[id_q]       = 1'b1;
    if (block_vld_q) mask[block_id_q] = 1'b1;
    req = ip_i & ie_i & ~mask;
  end

  clic_max_tree #(.NumSrc(NumSrc)) u_tree (
    .req_i  (req),
    .ctl_i  (ctl_i),
    .mode_i (mode_i),
    .shv_i  (shv_i),
    .win_o  (win)
  );

  // Threshold is sampled with the candidate so both describe the same cycle.
  assign eligible     = cand_q.valid && (cand_q.level > thresh_q);
  assign offered_live = ip_i[id_q] & ie_i[id_q];
  assign outranked    = cand_q.valid && (cand_q.level > level_q);
  assign below        = (level_q <= thresh_i);

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    kill_d      = kill_q;
    id_d        = id_q;
    level_d     = level_q;
    priv_d      = priv_q;
    shv_d       = shv_q;
    block_vld_d = accept;
    block_id_d  = id_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        kill_d  = 1'b0;
        if (eligible) begin
          id_d    = cand_q.id;
          level_d = cand_q.level;
          priv_d  = cand_q.priv;
          shv_d   = cand_q.shv;
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (irq_ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (!offered_live || outranked || below) begin
          valid_d = 1'b0;
          kill_d  = 1'b1;
          state_d = KILL;
        end
      end
      KILL: begin
        if (irq_kill_ack_i) begin
          kill_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        kill_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      thresh_q    <= '0;
      valid_q     <= 1'b0;
      kill_q      <= 1'b0;
      id_q        <= '0;
      level_q     <= '0;
      priv_q      <= '0;
      shv_q       <= 1'b0;
      block_vld_q <= 1'b0;
      block_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= win;
      thresh_q    <= thresh_i;
      valid_q     <= valid_d;
      kill_q      <= kill_d;
      id_q        <= id_d;
      level_q     <= level_d;
      priv_q      <= priv_d;
      shv_q       <= shv_d;
      block_vld_q <= block_vld_d;
      block_id_q  <= block_id_d;
    end
  end

  assign irq_valid_o    = valid_q;
  assign irq_kill_req_o = kill_q;
  assign irq_id_o       = id_q;
  assign irq_level_o    = level_q;
  assign irq_priv_o     = priv_q;
  assign irq_shv_o      = shv_q;
  assign accept_o       = accept;
  assign accept_id_o    = accept ? id_q : '0;
  assign dbg_state_o    = state_q;
endmodule

// File: doc/clic_irq_target.md
Name: clic_irq_target

Overview:
- CLIC-side transmitter for the core's SCLIC interrupt port.
- Each cycle it arbitrates among pending, enabled sources (up to 256) and offers the winner to the core with a valid/ready handshake.
- It withdraws an offer with a kill request/acknowledge exchange when the offer becomes stale or is outranked.
- It sits between the CLIC register file (ip/ie/attr/ctl per source) and the CVA6 clic_irq_* inputs.

Parameters:
- NumSrc, 256, number of interrupt sources.
- SrcW, $clog2(NumSrc), width of an interrupt ID.
- LvlW, 8, width of clicintctl level/priority.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- ip_i  in  NumSrc  pending bit per source
- ie_i  in  NumSrc  enable bit per source
- ctl_i  in  NumSrc*LvlW  level per source, source k at bits [k*LvlW +: LvlW]
- mode_i  in  NumSrc*2  privilege attribute per source
- shv_i  in  NumSrc  selective-hardware-vectoring attribute per source
- thresh_i  in  LvlW  interrupt threshold from mintthresh
- irq_valid_o  out  1  offer valid
- irq_ready_i  in  1  core accepts offer
- irq_id_o  out  SrcW  offered ID
- irq_level_o  out  LvlW  offered level
- irq_priv_o  out  2  offered privilege
- irq_shv_o  out  1  offered shv
- irq_kill_req_o  out  1  withdraw request
- irq_kill_ack_i  in  1  core confirms withdrawal
- accept_o  out  1  one-cycle pulse on handshake
- accept_id_o  out  SrcW  ID accepted; the register file clears edge-triggered ip from this

Behaviour:
- Reset: all outputs 0; FSM in IDLE; candidate register invalid.
- Arbitration is combinational over sources with ip&ie.
  - Highest ctl wins.
  - On equal ctl, the higher ID wins.
  - Winner is registered into the candidate {valid, id, level, priv, shv} every cycle.
- Eligibility: candidate valid && candidate level > thresh_i (unsigned compare).
- Latency: ip rises in cycle t → candidate registered at t+1 → irq_valid_o high at t+2.
- IDLE:
  - If eligible, latch the candidate into the output registers, drive irq_valid_o=1 and go to SEND.
- SEND:
  - irq_id/level/priv/shv are stable while irq_valid_o=1.
  - If irq_ready_i=1: accept_o=1 with accept_id_o=irq_id_o for that cycle; irq_valid_o=0 next cycle; go to IDLE.
  - Else, if the offered source has ip&ie=0, or a candidate with level > irq_level_o exists, or irq_level_o <= thresh_i: irq_valid_o=0, irq_kill_req_o=1, go to KILL.
  - Simultaneous ready and kill condition: ready wins and the handshake completes; no kill.
- KILL:
  - irq_kill_req_o held at 1 until irq_kill_ack_i=1.
  - On ack: kill_req=0 next cycle; go to IDLE. A new offer can go out no earlier than the following cycle.
  - irq_ready_i is ignored in KILL.
- IDLE never asserts kill; KILL never asserts valid.
- After an accept, the pending source may still read ip=1 for one cycle because of the register-file clear latency. To prevent a double offer, IDLE blocks re-offer of accept_id for the one cycle after accept.
- Async reset mid-SEND or mid-KILL drops valid/kill_req immediately. The core is required to tolerate this because it is reset by the same rst_ni.
- Level equal to thresh_i is not eligible.

Decomposition:
- Shared package clic_pkg holds:
  - clic_cand_t struct {valid, id[SrcW], level[LvlW], priv[1:0], shv}
  - FSM enum {IDLE, SEND, KILL}
- Sub-module clic_max_tree: parameterised log2(NumSrc)-deep comparator tree that returns the winning clic_cand_t, with the tie-break on higher ID.

Test Plan:
- Single source 5, ctl=0x40, thresh=0 → valid at t+2 with id=5, level=0x40; ready at t+3 → accept_o pulse, accept_id_o=5, valid=0 at t+4.
- Sources 3 and 9, both ctl=0x80 → id=9 offered; sources 3 (ctl=0x90) and 9 (ctl=0x80) → id=3 offered.
- Offer id=7 level=0x20, ready held low; raise source 12 with ctl=0x60 → kill_req=1 and valid=0; ack after 3 cycles → kill_req drops, then id=12 is offered.
- Offer id=4; clear ie[4] in the same cycle as ready=1 → accept completes for id=4, no kill_req.
- thresh_i=0x40 with source ctl=0x40 → never valid; thresh lowered to 0x3F → offered 2 cycles later.
- Async reset asserted during KILL → valid=0, kill_req=0, accept_o=0 immediately; after release with the same pending source → normal offer at t+2.
